// File: rtl/quad_encoder_emulator.sv
// Quadrature A/B generator: CW/CCW step requests accumulate in a signed counter
// and are played out as single, rate-limited A/B edges.
module quad_encoder_emulator #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cw_req,
    input  logic             ccw_req,
    input  logic             en,
    input  logic             clear,
    input  logic [DIV_W-1:0] period,
    output logic             a,
    output logic             b,
    output logic             step_cw,
    output logic             step_ccw,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             sat_err
);

    // Limits and unit steps at CNT_W+1 bits so the sum cannot wrap before the check
    localparam logic signed [CNT_W:0] MaxVal   = {2'b00, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W:0] MinVal   = {2'b11, {(CNT_W-1){1'b0}}};
    localparam logic signed [CNT_W:0] One      = {{CNT_W{1'b0}}, 1'b1};
    localparam logic signed [CNT_W:0] MinusOne = {(CNT_W+1){1'b1}};

    logic signed [CNT_W-1:0] pend_q, pend_d;
    logic [DIV_W-1:0]        timer_q, timer_d;
    logic                    a_q, a_d, b_q, b_d;
    logic                    scw_q, scw_d, sccw_q, sccw_d;
    logic                    sat_q, sat_d, busy_q, busy_d;
    logic                    emit, dir_cw;
    logic signed [CNT_W:0]   delta, sum;

    always_comb begin
        emit   = en && (pend_q != '0) && (timer_q == '0) && !clear;
        dir_cw = !pend_q[CNT_W-1];

        delta = '0;
        if (cw_req && !ccw_req) begin
            delta = One;
        end else if (ccw_req && !cw_req) begin
            delta = MinusOne;
        end

        sum = {pend_q[CNT_W-1], pend_q} + delta;
        if (emit) begin
            sum = dir_cw ? sum - One : sum + One;
        end

        sat_d  = 1'b0;
        pend_d = sum[CNT_W-1:0];
        if (clear) begin
            pend_d = '0;
        end else if (sum > MaxVal) begin
            pend_d = MaxVal[CNT_W-1:0];
            sat_d  = 1'b1;
        end else if (sum < MinVal) begin
            pend_d = MinVal[CNT_W-1:0];
            sat_d  = 1'b1;
        end
        busy_d = (pend_d != '0);

        timer_d = timer_q;
        if (emit) begin
            timer_d = (period == '0) ? '0 : period - 1'b1;
        end else if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
        end

        // Gray step: CW walks 00->10->11->01, CCW walks the reverse
        a_d    = a_q;
        b_d    = b_q;
        scw_d  = 1'b0;
        sccw_d = 1'b0;
        if (emit) begin
            if (dir_cw) begin
                a_d   = ~b_q;
                b_d   = a_q;
                scw_d = 1'b1;
            end else begin
                a_d    = b_q;
                b_d    = ~a_q;
                sccw_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= '0;
            timer_q <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            scw_q   <= 1'b0;
            sccw_q  <= 1'b0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            timer_q <= timer_d;
            a_q     <= a_d;
            b_q     <= b_d;
            scw_q   <= scw_d;
            sccw_q  <= sccw_d;
            sat_q   <= sat_d;
            busy_q  <= busy_d;
        end
    end

    assign a        = a_q;
    assign b        = b_q;
    assign step_cw  = scw_q;
    assign step_ccw = sccw_q;
    assign pending  = pend_q;
    assign busy     = busy_q;
    assign sat_err  = sat_q;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Bench for quad_encoder_emulator: position-based reference model compared every
// cycle, a loopback quadrature decoder, and directed scenarios with literal expectations.
module tb_quad_encoder_emulator;

    localparam int CW   = 4;
    localparam int DW   = 8;
    localparam int MAXV = 7;
    localparam int MINV = -8;

    logic          clk = 1'b0;
    logic          rst, cw_req, ccw_req, en, clear;
    logic [DW-1:0] period;
    logic          a, b, step_cw, step_ccw, busy, sat_err;
    logic [CW-1:0] pending;
    logic signed [CW-1:0] pend_s;

    assign pend_s = pending;

    quad_encoder_emulator #(.CNT_W(CW), .DIV_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .cw_req   (cw_req),
        .ccw_req  (ccw_req),
        .en       (en),
        .clear    (clear),
        .period   (period),
        .a        (a),
        .b        (b),
        .step_cw  (step_cw),
        .step_ccw (step_ccw),
        .pending  (pending),
        .busy     (busy),
        .sat_err  (sat_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] ab_of(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic int pos_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Inputs seen at each rising edge, replayed into the model on the falling edge
    int      pcnt = 0;
    logic    s_rst = 1'b1, s_cw, s_ccw, s_en, s_clear;
    int      s_per;
    always @(posedge clk) begin
        pcnt    <= pcnt + 1;
        s_rst   <= rst;
        s_cw    <= cw_req;
        s_ccw   <= ccw_req;
        s_en    <= en;
        s_clear <= clear;
        s_per   <= int'(period);
    end

    // Reference state: signed backlog, edge gap countdown, phase position mod 4
    int m_pend, m_timer, m_pos;
    bit m_scw, m_sccw, m_sat;

    task automatic model_step();
        bit go;
        int dir, nxt;
        go     = s_en && (m_pend != 0) && (m_timer == 0) && !s_clear;
        dir    = (m_pend > 0) ? 1 : -1;
        m_scw  = go && (dir == 1);
        m_sccw = go && (dir == -1);
        if (go) begin
            m_pos   = (m_pos + dir + 4) % 4;
            m_timer = ((s_per == 0) ? 1 : s_per) - 1;
        end else if (m_timer > 0) begin
            m_timer = m_timer - 1;
        end
        m_sat = 0;
        if (s_clear) begin
            m_pend = 0;
        end else begin
            nxt = m_pend + int'(s_cw) - int'(s_ccw) - (go ? dir : 0);
            if (nxt > MAXV) begin
                m_pend = MAXV;
                m_sat  = 1;
            end else if (nxt < MINV) begin
                m_pend = MINV;
                m_sat  = 1;
            end else begin
                m_pend = nxt;
            end
        end
    endtask

    logic [1:0] ev_ab[$];
    int         ev_cyc[$];
    int         ev_dir[$];
    int         sat_cnt, n_cw, n_ccw, dec_cw, dec_ccw, min_pend;
    logic [1:0] prev_ab = 2'b00;

    always @(negedge clk) begin
        int diff;
        if (rst || s_rst) begin
            m_pend = 0; m_timer = 0; m_pos = 0;
            m_scw = 0; m_sccw = 0; m_sat = 0;
        end else begin
            model_step();
        end
        check("ab", int'({a, b}), int'(ab_of(m_pos)));
        check("step_cw", int'(step_cw), int'(m_scw));
        check("step_ccw", int'(step_ccw), int'(m_sccw));
        check("pending", int'(pend_s), m_pend);
        check("busy", int'(busy), int'(m_pend != 0));
        check("sat_err", int'(sat_err), int'(m_sat));
        if (rst) begin
            prev_ab = 2'b00;
        end else begin
            diff = (pos_of({a, b}) - pos_of(prev_ab) + 4) % 4;
            check("single_toggle", int'(diff == 2), 0);
            if (diff == 1) dec_cw++;
            if (diff == 3) dec_ccw++;
            if (step_cw) begin
                n_cw++;
                ev_ab.push_back({a, b}); ev_cyc.push_back(pcnt); ev_dir.push_back(1);
            end
            if (step_ccw) begin
                n_ccw++;
                ev_ab.push_back({a, b}); ev_cyc.push_back(pcnt); ev_dir.push_back(-1);
            end
            if (sat_err) sat_cnt++;
            if (int'(pend_s) < min_pend) min_pend = int'(pend_s);
            prev_ab = {a, b};
        end
    end

    task automatic clear_log();
        @(posedge clk);
        #1;
        ev_ab.delete(); ev_cyc.delete(); ev_dir.delete();
        sat_cnt = 0; n_cw = 0; n_ccw = 0; dec_cw = 0; dec_ccw = 0; min_pend = 0;
    endtask

    task automatic cycle(input logic c, input logic cc);
        @(negedge clk);
        cw_req  = c;
        ccw_req = cc;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Checks a logged edge train against literal phases, one direction and a fixed gap
    task automatic check_train(input string name, input int n, input logic [1:0] exp_ab[8],
                               input int dir, input int gap, input int first_cyc);
        check({name, "_edges"}, ev_ab.size(), n);
        for (int i = 0; i < n && i < ev_ab.size(); i++) begin
            check({name, "_phase"}, int'(ev_ab[i]), int'(exp_ab[i]));
            check({name, "_dir"}, ev_dir[i], dir);
            if (i > 0) check({name, "_gap"}, ev_cyc[i] - ev_cyc[i-1], gap);
        end
        if (ev_cyc.size() > 0) check({name, "_latency"}, ev_cyc[0], first_cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         t0, k;
        logic [1:0] exp_ab[8];

        rst = 1'b1; cw_req = 1'b0; ccw_req = 1'b0; en = 1'b1; clear = 1'b0; period = 8'd3;
        #1;
        check("reset_ab", int'({a, b}), 0);
        check("reset_pending", int'(pend_s), 0);
        check("reset_flags", int'({step_cw, step_ccw, busy, sat_err}), 0);
        @(posedge clk); @(posedge clk); #2 rst = 1'b0;

        // T1: four CW requests, period 3
        clear_log();
        @(negedge clk); t0 = pcnt; cw_req = 1'b1;
        repeat (3) cycle(1'b1, 1'b0);
        idle(14);
        settle();
        exp_ab = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        check_train("t1", 4, exp_ab, 1, 3, t0 + 2);
        check("t1_busy", int'(busy), 0);

        // T2: period 0, five CCW requests back to back
        clear_log();
        @(negedge clk); t0 = pcnt; period = 8'd0; ccw_req = 1'b1;
        repeat (4) cycle(1'b0, 1'b1);
        idle(6);
        settle();
        exp_ab = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
        check_train("t2", 5, exp_ab, -1, 1, t0 + 2);
        check("t2_pending", int'(pend_s), 0);

        // T3: simultaneous requests cancel
        clear_log();
        repeat (10) cycle(1'b1, 1'b1);
        idle(3);
        settle();
        check("t3_edges", ev_ab.size(), 0);
        check("t3_sat", sat_cnt, 0);
        check("t3_pending", int'(pend_s), 0);
        check("t3_ab", int'({a, b}), int'(2'b01));

        // T4: saturate while disabled, then drain
        clear_log();
        @(negedge clk); en = 1'b0; cw_req = 1'b1;
        repeat (8) cycle(1'b1, 1'b0);
        idle(1);
        settle();
        check("t4_pending", int'(pend_s), 7);
        check("t4_sat", sat_cnt, 2);
        check("t4_no_edges", ev_ab.size(), 0);
        @(negedge clk); en = 1'b1; period = 8'd2;
        idle(20);
        settle();
        check("t4_cw_edges", n_cw, 7);
        check("t4_ccw_edges", n_ccw, 0);
        check("t4_ab", int'({a, b}), int'(2'b11));

        // T5: reverse direction while CW edges are still pending
        clear_log();
        @(negedge clk); en = 1'b0; period = 8'd4; cw_req = 1'b1;
        repeat (4) cycle(1'b1, 1'b0);
        idle(1);
        @(negedge clk); en = 1'b1;
        k = 0;
        do begin
            settle();
            k++;
        end while (int'(pend_s) != 3 && k < 40);
        check("t5_reach_three", int'(k < 40), 1);
        repeat (5) cycle(1'b0, 1'b1);
        idle(15);
        settle();
        check("t5_cw_edges", n_cw, 2);
        check("t5_ccw_edges", n_ccw, 2);
        check("t5_min_pending", min_pend, -1);
        check("t5_pending", int'(pend_s), 0);
        check("t5_ab", int'({a, b}), int'(2'b11));

        // Clear drops the backlog and the same-cycle request, phase untouched
        clear_log();
        @(negedge clk); en = 1'b0; cw_req = 1'b1;
        repeat (2) cycle(1'b1, 1'b0);
        @(negedge clk); clear = 1'b1; cw_req = 1'b1;
        @(negedge clk); clear = 1'b0; cw_req = 1'b0; en = 1'b1;
        idle(5);
        settle();
        check("clr_pending", int'(pend_s), 0);
        check("clr_edges", ev_ab.size(), 0);
        check("clr_ab", int'({a, b}), int'(2'b11));

        // T6: random traffic with mid-run resets, loopback decoder
        clear_log();
        for (int i = 0; i < 300; i++) begin
            if (i == 100 || i == 200) begin
                @(posedge clk);
                #2 rst = 1'b1;
                #1;
                check("t6_rst_ab", int'({a, b}), 0);
                check("t6_rst_pending", int'(pend_s), 0);
                @(posedge clk);
                #2 rst = 1'b0;
            end
            @(negedge clk);
            cw_req  = 1'($urandom_range(0, 1));
            ccw_req = 1'($urandom_range(0, 1));
            en      = ($urandom_range(0, 7) != 0);
            clear   = ($urandom_range(0, 31) == 0);
            period  = DW'($urandom_range(0, 3));
        end
        @(negedge clk); cw_req = 1'b0; ccw_req = 1'b0; en = 1'b1; clear = 1'b0;
        idle(40);
        settle();
        check("t6_dec_cw", dec_cw, n_cw);
        check("t6_dec_ccw", dec_ccw, n_ccw);
        check("t6_pending", int'(pend_s), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
